// File: rtl/pe_array_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pe_array_sequencer
// Description : Tile control FSM for a square systolic PE array. It clears the
//               array, feeds operand beats, flushes the skew and pipeline,
//               waits for the reduction and reads the result out row by row.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_array_sequencer #(
  parameter int ARRAY_DIM  = 4,
  parameter int PIPE_STAGE = 2,
  parameter int K_BITS     = 10
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              start,
  input  logic [K_BITS-1:0]                                 k_len,
  input  logic                                              abort,
  output logic                                              busy,
  output logic                                              done,
  output logic                                              err,
  output logic                                              feed_req,
  input  logic                                              feed_ack,
  output logic                                              feed_zero,
  output logic                                              pe_reset,
  output logic                                              pe_done,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [((ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1)-1:0] out_row
);

  localparam int ROW_W        = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
  localparam int c_flush_cyc  = 2 * (ARRAY_DIM - 1) + PIPE_STAGE + 2;
  localparam int c_reduce_cyc = 2 * PIPE_STAGE + 3;
  localparam int c_k_max      = (1 << K_BITS) - 1;
  localparam int c_cnt_max0   = (c_k_max > c_flush_cyc) ? c_k_max : c_flush_cyc;
  localparam int c_cnt_max    = (c_cnt_max0 > c_reduce_cyc) ? c_cnt_max0 : c_reduce_cyc;
  localparam int CNT_W        = $clog2(c_cnt_max + 1);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_clear   = 3'd1;
  localparam logic [2:0] c_st_feed    = 3'd2;
  localparam logic [2:0] c_st_flush   = 3'd3;
  localparam logic [2:0] c_st_done    = 3'd4;
  localparam logic [2:0] c_st_reduce  = 3'd5;
  localparam logic [2:0] c_st_readout = 3'd6;

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [K_BITS-1:0] r_k_len;
  logic [ROW_W-1:0]  r_row;
  logic              r_done;
  logic              r_err;
  logic              r_abort_clr;
  logic              w_abort;
  logic              w_last_row;

  assign w_abort    = abort && (r_state != c_st_idle);
  assign w_last_row = (r_row == ROW_W'(ARRAY_DIM - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= c_st_idle;
      r_cnt       <= '0;
      r_k_len     <= '0;
      r_row       <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_abort_clr <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_abort_clr <= 1'b0;
      if (w_abort) begin
        // Abort beats every other transition; the array gets one extra clear.
        r_state     <= c_st_idle;
        r_cnt       <= '0;
        r_row       <= '0;
        r_abort_clr <= 1'b1;
      end else begin
        case (r_state)
          c_st_idle: begin
            if (start) begin
              if (k_len == '0) begin
                r_err <= 1'b1;
              end else begin
                r_k_len <= k_len;
                r_state <= c_st_clear;
              end
            end
          end
          c_st_clear: begin
            r_cnt   <= CNT_W'(r_k_len);
            r_state <= c_st_feed;
          end
          c_st_feed: begin
            if (feed_ack) begin
              if (r_cnt == CNT_W'(1)) begin
                r_cnt   <= CNT_W'(c_flush_cyc - 1);
                r_state <= c_st_flush;
              end else begin
                r_cnt <= r_cnt - CNT_W'(1);
              end
            end
          end
          c_st_flush: begin
            if (r_cnt == '0) begin
              r_state <= c_st_done;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          c_st_done: begin
            r_cnt   <= CNT_W'(c_reduce_cyc - 1);
            r_state <= c_st_reduce;
          end
          c_st_reduce: begin
            if (r_cnt == '0) begin
              r_row   <= '0;
              r_state <= c_st_readout;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          c_st_readout: begin
            if (out_ready) begin
              if (w_last_row) begin
                r_row   <= '0;
                r_done  <= 1'b1;
                r_state <= c_st_idle;
              end else begin
                r_row <= r_row + ROW_W'(1);
              end
            end
          end
          default: begin
            r_state <= c_st_idle;
          end
        endcase
      end
    end
  end

  // Edge operands are zeroed on feed bubbles and for the whole drain phase.
  assign feed_zero = ((r_state == c_st_feed) && !feed_ack) ||
                     (r_state == c_st_flush)  || (r_state == c_st_done) ||
                     (r_state == c_st_reduce) || (r_state == c_st_readout);
  assign busy      = (r_state != c_st_idle);
  assign feed_req  = (r_state == c_st_feed);
  assign pe_reset  = (r_state == c_st_clear) || r_abort_clr;
  assign pe_done   = (r_state == c_st_done);
  assign out_valid = (r_state == c_st_readout);
  assign out_row   = r_row;
  assign done      = r_done;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pe_array_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_array_sequencer
// Description : Directed bench for pe_array_sequencer at ARRAY_DIM=4,
//               PIPE_STAGE=2 (flush 10 cycles, reduce 7 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_array_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] k_len;
  logic       abort;
  logic       busy;
  logic       done;
  logic       err;
  logic       feed_req;
  logic       feed_ack;
  logic       feed_zero;
  logic       pe_reset;
  logic       pe_done;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_row;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  pe_array_sequencer #(
    .ARRAY_DIM  (4),
    .PIPE_STAGE (2),
    .K_BITS     (10)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .k_len     (k_len),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .feed_req  (feed_req),
    .feed_ack  (feed_ack),
    .feed_zero (feed_zero),
    .pe_reset  (pe_reset),
    .pe_done   (pe_done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present start for one edge; afterwards cyc==1 is the first cycle after it.
  task automatic launch(input logic [9:0] k);
    cyc   = 0;
    start = 1'b1;
    k_len = k;
    tick();
    start = 1'b0;
    k_len = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},      busy,      0);
    check({tag, " done"},      done,      0);
    check({tag, " err"},       err,       0);
    check({tag, " feed_req"},  feed_req,  0);
    check({tag, " feed_zero"}, feed_zero, 0);
    check({tag, " pe_reset"},  pe_reset,  0);
    check({tag, " pe_done"},   pe_done,   0);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " out_row"},   out_row,   0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc;
    int beats;
    int done_cyc;
    int n_done;
    int exp_row[9] = '{0, 1, 2, 2, 2, 2, 2, 2, 3};

    reset     = 1'b1;
    start     = 1'b0;
    k_len     = '0;
    abort     = 1'b0;
    feed_ack  = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();
    check("post-reset busy", busy, 0);

    // Nominal tile, k_len=8, everything tied ready.
    launch(10'd8);
    while (cyc <= 32) begin
      check($sformatf("t1 busy c%0d", cyc),      busy,      (cyc <= 31));
      check($sformatf("t1 pe_reset c%0d", cyc),  pe_reset,  (cyc == 1));
      check($sformatf("t1 feed_req c%0d", cyc),  feed_req,  (cyc >= 2 && cyc <= 9));
      check($sformatf("t1 feed_zero c%0d", cyc), feed_zero, (cyc >= 10 && cyc <= 31));
      check($sformatf("t1 pe_done c%0d", cyc),   pe_done,   (cyc == 20));
      check($sformatf("t1 out_valid c%0d", cyc), out_valid, (cyc >= 28 && cyc <= 31));
      if (cyc >= 28 && cyc <= 31)
        check($sformatf("t1 out_row c%0d", cyc), out_row, cyc - 28);
      check($sformatf("t1 done c%0d", cyc),      done,      (cyc == 32));
      tick();
    end

    // k_len=4 with a bubble on every other feed cycle, starting with a bubble.
    launch(10'd4);
    tick();
    fc    = 0;
    beats = 0;
    while (feed_req && fc < 20) begin
      feed_ack = (fc % 2 == 1);
      #1;
      check($sformatf("t2 feed_zero f%0d", fc), feed_zero, !feed_ack);
      if (feed_ack) beats++;
      fc++;
      tick();
    end
    feed_ack = 1'b1;
    check("t2 feed cycles", fc, 8);
    check("t2 beats", beats, 4);
    check("t2 flush feed_zero", feed_zero, 1);
    while (!done && cyc < 60) tick();
    check("t2 done cycle", cyc, 32);
    tick();

    // k_len=1, out_ready low for 5 cycles at row 2, plus a start while busy.
    launch(10'd1);
    while (cyc <= 30) begin
      out_ready = !(cyc >= 23 && cyc <= 27);
      start     = (cyc == 5);
      k_len     = '0;
      if (cyc == 6) begin
        check("t3 err ignored", err, 0);
        check("t3 busy kept", busy, 1);
      end
      check($sformatf("t3 out_valid c%0d", cyc), out_valid, (cyc >= 21 && cyc <= 29));
      if (cyc >= 21 && cyc <= 29)
        check($sformatf("t3 out_row c%0d", cyc), out_row, exp_row[cyc - 21]);
      check($sformatf("t3 done c%0d", cyc), done, (cyc == 30));
      tick();
    end
    start     = 1'b0;
    out_ready = 1'b1;

    // Abort during REDUCE, then an immediate new tile of k_len=2.
    launch(10'd1);
    while (cyc < 16) tick();
    check("t4 busy in reduce", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4 abort busy", busy, 0);
    check("t4 abort pe_reset", pe_reset, 1);
    check("t4 abort done", done, 0);
    check("t4 abort feed_zero", feed_zero, 0);
    launch(10'd2);
    check("t4 restart busy", busy, 1);
    while (cyc <= 26) begin
      check($sformatf("t4 pe_reset c%0d", cyc), pe_reset, (cyc == 1));
      check($sformatf("t4 done c%0d", cyc), done, (cyc == 26));
      tick();
    end

    // Start with k_len==0.
    launch(10'd0);
    check("t5 err pulse", err, 1);
    check("t5 busy", busy, 0);
    tick();
    check("t5 err cleared", err, 0);
    check("t5 busy after", busy, 0);

    // Asynchronous reset in the middle of FEED.
    launch(10'd8);
    while (cyc < 4) tick();
    check("t6 in feed", feed_req, 1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("t6 async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    check("t6 idle busy", busy, 0);
    check("t6 idle feed_req", feed_req, 0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) n_done++;
      tick();
    end
    check("t6 no done", n_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
